// File: rtl/dubl_pkg.sv
// dubl_pkg: shared types for the dubl_deser serial framer.
//   dubl_state_t : framer FSM state, 2-bit encoding
//     IDLE  - block disabled, nothing shifted
//     HUNT  - sliding-window search for the sync word
//     DATA  - assembling data words
//     CHECK - collecting the aligned sync word that closes a frame
package dubl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        DATA  = 2'd2,
        CHECK = 2'd3
    } dubl_state_t;

endpackage

// File: rtl/dubl_shreg.sv
// dubl_shreg: WIDTH-bit serial-in shift register with a combinational
// sync-word comparator on the value the register would hold after shifting.
// Ports:
//   dubl_clk  in   clock, posedge
//   rst_n     in   asynchronous active-low reset
//   clear     in   synchronous clear (takes priority over shift)
//   shift     in   shift din in at the LSB
//   din       in   serial bit
//   word      out  assembled data word: next-shift value, or the held
//                  register when the current bit is a trailing parity bit
//   match     out  next-shift value equals SYNC_PAT
module dubl_shreg #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] SYNC_PAT = 8'hA5,
    parameter bit               PARITY   = 1'b0
) (
    input  logic             dubl_clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] word,
    output logic             match
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nxt;

    assign nxt   = {q[WIDTH-2:0], din};
    assign match = (nxt == SYNC_PAT);
    // With a parity bit on the line, the data bits are already in q when the
    // parity bit arrives; otherwise the word completes with the current bit.
    assign word  = PARITY ? q : nxt;

    always_ff @(posedge dubl_clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (shift) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/dubl_deser.sv
// dubl_deser: serial-to-parallel framer on the double-edge pulse clock.
// Hunts for SYNC_PAT (sliding window), then emits WIDTH-bit words and checks
// one aligned sync word after every FRAME_WORDS data words. MISS_MAX
// consecutive bad sync words drop lock back to HUNT.
// Optional feature macro: DUBL_PARITY_EN (one even-parity bit after each data
// word, reported on par_err; the port exists only when the macro is defined).
// Ports:
//   dubl_clk   in   clock, all flops on posedge
//   rst_n      in   asynchronous active-low reset
//   en         in   enable; low forces IDLE synchronously
//   sdat_in    in   serial data, MSB first
//   word_out   out  last emitted data word, held between updates
//   word_vld   out  1-cycle pulse when word_out updates
//   locked     out  high while in DATA/CHECK
//   sync_err   out  1-cycle pulse on sync word mismatch
//   word_cnt   out  emitted word count, saturating
//   par_err    out  parity failure, pulses with word_vld (DUBL_PARITY_EN)
//   fsm_state  out  current FSM state (debug)
module dubl_deser
    import dubl_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_PAT    = 8'hA5,
    parameter int               FRAME_WORDS = 4,
    parameter int               MISS_MAX    = 2,
    parameter int               CNT_W       = 16
) (
    input  logic             dubl_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sdat_in,
    output logic [WIDTH-1:0] word_out,
    output logic             word_vld,
    output logic             locked,
    output logic             sync_err,
    output logic [CNT_W-1:0] word_cnt,
`ifdef DUBL_PARITY_EN
    output logic             par_err,
`endif
    output logic [1:0]       fsm_state
);

`ifdef DUBL_PARITY_EN
    localparam int FB     = WIDTH + 1;
    localparam bit PARITY = 1'b1;
`else
    localparam int FB     = WIDTH;
    localparam bit PARITY = 1'b0;
`endif
    localparam int BC_W = $clog2(FB + 1);
    localparam int WI_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int MC_W = $clog2(MISS_MAX + 1);

    dubl_state_t      state, state_nxt;
    logic [BC_W-1:0]  bit_cnt;
    logic [WI_W-1:0]  word_idx;
    logic [MC_W-1:0]  miss_cnt;

    logic             shift, clear, word_done, chk_done, match;
    logic [WIDTH-1:0] sh_word;

    dubl_shreg #(
        .WIDTH    (WIDTH),
        .SYNC_PAT (SYNC_PAT),
        .PARITY   (PARITY)
    ) u_shreg (
        .dubl_clk (dubl_clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .shift    (shift),
        .din      (sdat_in),
        .word     (sh_word),
        .match    (match)
    );

    assign fsm_state = state;

    always_ff @(posedge dubl_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        clear     = 1'b0;
        word_done = 1'b0;
        chk_done  = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            clear     = 1'b1;
        end else begin
            unique case (state)
                IDLE: state_nxt = HUNT;
                HUNT: begin
                    shift = 1'b1;
                    if (match) state_nxt = DATA;
                end
                DATA: begin
                    shift = 1'b1;
                    if (bit_cnt == BC_W'(FB - 1)) begin
                        word_done = 1'b1;
                        if (word_idx == WI_W'(FRAME_WORDS - 1)) state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    shift = 1'b1;
                    if (bit_cnt == BC_W'(WIDTH - 1)) begin
                        chk_done = 1'b1;
                        // The miss that reaches MISS_MAX gives up the flywheel.
                        if (!match && miss_cnt == MC_W'(MISS_MAX - 1)) state_nxt = HUNT;
                        else                                          state_nxt = DATA;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge dubl_clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            word_idx <= '0;
            miss_cnt <= '0;
            word_out <= '0;
            word_vld <= 1'b0;
            sync_err <= 1'b0;
            locked   <= 1'b0;
            word_cnt <= '0;
`ifdef DUBL_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
            word_vld <= 1'b0;
            sync_err <= 1'b0;
`ifdef DUBL_PARITY_EN
            par_err  <= 1'b0;
`endif
            locked   <= (state_nxt == DATA) || (state_nxt == CHECK);
            if (!en) begin
                bit_cnt  <= '0;
                word_idx <= '0;
                miss_cnt <= '0;
            end else begin
                unique case (state)
                    HUNT: begin
                        if (match) begin
                            bit_cnt  <= '0;
                            word_idx <= '0;
                            miss_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (word_done) begin
                            bit_cnt  <= '0;
                            word_out <= sh_word;
                            word_vld <= 1'b1;
`ifdef DUBL_PARITY_EN
                            // Even parity: data plus parity bit must hold an even count of ones.
                            par_err  <= ^{sh_word, sdat_in};
`endif
                            if (word_cnt != {CNT_W{1'b1}}) word_cnt <= word_cnt + 1'b1;
                            if (word_idx == WI_W'(FRAME_WORDS - 1)) word_idx <= '0;
                            else                                    word_idx <= word_idx + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (chk_done) begin
                            bit_cnt <= '0;
                            if (match) begin
                                miss_cnt <= '0;
                            end else begin
                                sync_err <= 1'b1;
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
